// File: rtl/onehot_encoder_pipe.sv
// rtl/onehot_encoder_pipe.sv - registered, handshaked one-hot to binary priority encoder
//
// Accepts an N-bit request vector through a valid/ready handshake and encodes it
// to the index of its highest set bit. Zero-hot and multi-hot words are flagged
// and counted. The input is backed by a one-entry skid buffer, so in_ready is a
// registered signal with no combinational path from out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid this cycle
//   in_ready   block can accept in_data this cycle (registered)
//   in_data    N-bit one-hot request vector
//   out_valid  out_code/out_zero/out_multi are valid
//   out_ready  downstream accepts the output this cycle
//   out_code   index of the highest set bit of the accepted word (0 if none)
//   out_zero   accepted word had no bits set
//   out_multi  accepted word had more than one bit set
//   clr_err    synchronous clear of err_count
//   err_count  saturating count of invalid words accepted
module onehot_encoder_pipe #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_zero,
  output logic             out_multi,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count
);

  if (N < 2 || W != $clog2(N) || (1 << W) != N) begin : g_param_check
    $error("onehot_encoder_pipe: N must be a power of 2 >= 2 and W must equal log2(N)");
  end

  logic [W-1:0] enc_code;
  logic         enc_seen;
  logic         enc_multi;
  logic         enc_zero;

  logic         skid_full;
  logic [W-1:0] skid_code;
  logic         skid_zero;
  logic         skid_multi;

  logic         in_fire;
  logic         out_load;
  logic         err_inc;

  // Ascending scan: the last set bit found is the highest one. A set bit seen
  // after an earlier one marks the word as multi-hot.
  always_comb begin
    enc_code  = '0;
    enc_seen  = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_data[i]) begin
        enc_code  = W'(i);
        enc_multi = enc_multi | enc_seen;
        enc_seen  = 1'b1;
      end
    end
    enc_zero = ~enc_seen;
  end

  assign in_ready = ~skid_full;
  assign in_fire  = in_valid & in_ready;
  // The output register may take a new value whenever it is empty or draining.
  assign out_load = ~out_valid | out_ready;
  assign err_inc  = in_fire & (enc_zero | enc_multi);

  // Output stage and skid buffer. The skid is only written when the output
  // stage cannot take the word; whenever the output stage loads, the skid
  // (older data) wins over the new input. While the skid is full, in_ready is
  // low, so in_fire and a skid drain never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_zero   <= 1'b0;
      out_multi  <= 1'b0;
      skid_full  <= 1'b0;
      skid_code  <= '0;
      skid_zero  <= 1'b0;
      skid_multi <= 1'b0;
    end else begin
      if (out_load) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_code  <= skid_code;
          out_zero  <= skid_zero;
          out_multi <= skid_multi;
        end else if (in_fire) begin
          out_valid <= 1'b1;
          out_code  <= enc_code;
          out_zero  <= enc_zero;
          out_multi <= enc_multi;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (in_fire && !out_load) begin
        skid_full  <= 1'b1;
        skid_code  <= enc_code;
        skid_zero  <= enc_zero;
        skid_multi <= enc_multi;
      end else if (out_load) begin
        skid_full  <= 1'b0;
      end
    end
  end

  // Errors are counted at acceptance. A clear in the same cycle as an invalid
  // acceptance leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= err_inc ? CNT_W'(1) : '0;
    end else if (err_inc && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb/tb_onehot_encoder_pipe.sv - self-checking bench for onehot_encoder_pipe (N=4 and N=8 instances)
module tb_onehot_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Instance A: N=4, directed tests
  logic       a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0] a_in_data;
  logic [1:0] a_out_code;
  logic       a_out_zero, a_out_multi, a_clr_err;
  logic [7:0] a_err_count;

  // Instance B: N=8, random handshake test
  logic       b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data;
  logic [2:0] b_out_code;
  logic       b_out_zero, b_out_multi, b_clr_err;
  logic [7:0] b_err_count;

  onehot_encoder_pipe #(.N(4), .W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_code(a_out_code), .out_zero(a_out_zero), .out_multi(a_out_multi),
    .clr_err(a_clr_err), .err_count(a_err_count)
  );

  onehot_encoder_pipe #(.N(8), .W(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .out_zero(b_out_zero), .out_multi(b_out_multi),
    .clr_err(b_clr_err), .err_count(b_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding, packed as {multi, zero, code[2:0]}
  function automatic logic [4:0] model(input logic [7:0] d);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) begin
        c = 3'(i);
        break;
      end
    end
    return {($countones(d) > 1), (d == 8'd0), c};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] qa[$];
  logic [4:0] qb[$];
  int         b_outs = 0;

  // Scoreboard A: push at input transfer, pop and compare at output transfer
  always @(negedge clk) begin
    logic [4:0] e;
    if (!a_rst_n) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          chk("a_sb_spurious_output", 32'd1, 32'd0);
        end else begin
          e = qa.pop_front();
          chk("a_sb_code",  {30'd0, a_out_code}, {29'd0, e[2:0]});
          chk("a_sb_zero",  {31'd0, a_out_zero}, {31'd0, e[3]});
          chk("a_sb_multi", {31'd0, a_out_multi}, {31'd0, e[4]});
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(model({4'd0, a_in_data}));
    end
  end

  // Scoreboard B plus output-stability check while stalled
  logic       b_prev_stall = 1'b0;
  logic [4:0] b_held;
  always @(negedge clk) begin
    logic [4:0] e;
    if (!b_rst_n) begin
      qb.delete();
      b_prev_stall = 1'b0;
    end else begin
      if (b_prev_stall) begin
        chk("b_stall_valid", {31'd0, b_out_valid}, 32'd1);
        chk("b_stall_hold", {27'd0, b_out_multi, b_out_zero, b_out_code}, {27'd0, b_held});
      end
      if (b_out_valid && b_out_ready) begin
        b_outs++;
        if (qb.size() == 0) begin
          chk("b_sb_spurious_output", 32'd1, 32'd0);
        end else begin
          e = qb.pop_front();
          chk("b_sb_word", {27'd0, b_out_multi, b_out_zero, b_out_code}, {27'd0, e});
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(model(b_in_data));
      b_prev_stall = b_out_valid & ~b_out_ready;
      b_held       = {b_out_multi, b_out_zero, b_out_code};
    end
  end

  initial begin
    int sent;
    int inv;
    int guard;
    int r;

    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_clr_err = 1'b0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_clr_err = 1'b0;
    repeat (2) cyc();

    // Reset state
    chk("rst_in_ready",  {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_code",  {30'd0, a_out_code}, 32'd0);
    chk("rst_out_zero",  {31'd0, a_out_zero}, 32'd0);
    chk("rst_out_multi", {31'd0, a_out_multi}, 32'd0);
    chk("rst_err_count", {24'd0, a_err_count}, 32'd0);
    a_rst_n = 1'b1;
    cyc();

    // Test 1: back-to-back one-hot words, one cycle latency
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 4'(1 << i);
      cyc();
      chk("t1_out_valid", {31'd0, a_out_valid}, 32'd1);
      chk("t1_out_code",  {30'd0, a_out_code}, 32'(i));
      chk("t1_flags",     {30'd0, a_out_zero, a_out_multi}, 32'd0);
    end
    a_in_valid = 1'b0;
    cyc();
    chk("t1_idle_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t1_err_count", {24'd0, a_err_count}, 32'd0);

    // Test 2: zero-hot and multi-hot words
    a_in_valid = 1'b1; a_in_data = 4'b0000;
    cyc();
    chk("t2_zero_code", {30'd0, a_out_code}, 32'd0);
    chk("t2_zero_flags", {30'd0, a_out_zero, a_out_multi}, 32'b10);
    a_in_data = 4'b1010;
    cyc();
    chk("t2_multi_code", {30'd0, a_out_code}, 32'd3);
    chk("t2_multi_flags", {30'd0, a_out_zero, a_out_multi}, 32'b01);
    chk("t2_err_count", {24'd0, a_err_count}, 32'd2);
    a_in_valid = 1'b0;
    cyc();

    // Test 3: backpressure fills output then skid
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 4'b0010;
    cyc();
    chk("t3_first_code", {30'd0, a_out_code}, 32'd1);
    chk("t3_ready_after_first", {31'd0, a_in_ready}, 32'd1);
    a_in_data = 4'b1000;
    cyc();
    chk("t3_ready_after_second", {31'd0, a_in_ready}, 32'd0);
    chk("t3_hold_code", {30'd0, a_out_code}, 32'd1);
    a_in_data = 4'b0100;  // ignored: skid full
    cyc();
    chk("t3_ready_still_low", {31'd0, a_in_ready}, 32'd0);
    chk("t3_hold_code2", {30'd0, a_out_code}, 32'd1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    cyc();
    chk("t3_drain_code", {30'd0, a_out_code}, 32'd3);
    chk("t3_drain_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t3_ready_back", {31'd0, a_in_ready}, 32'd1);
    cyc();
    chk("t3_empty", {31'd0, a_out_valid}, 32'd0);

    // Test 4: saturation and clear-with-increment
    a_in_valid = 1'b1; a_in_data = 4'b0000;
    repeat (300) cyc();
    chk("t4_saturated", {24'd0, a_err_count}, 32'd255);
    a_in_data = 4'b0011; a_clr_err = 1'b1;
    cyc();
    chk("t4_clear_and_inc", {24'd0, a_err_count}, 32'd1);
    a_in_valid = 1'b0;
    cyc();
    chk("t4_clear_only", {24'd0, a_err_count}, 32'd0);
    a_clr_err = 1'b0;
    cyc();

    // Test 5: asynchronous reset with both stages full
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 4'b0000;
    cyc();
    a_in_data = 4'b0100;
    cyc();
    a_in_valid = 1'b0;
    chk("t5_full_ready", {31'd0, a_in_ready}, 32'd0);
    chk("t5_err_before", {24'd0, a_err_count}, 32'd1);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t5_async_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("t5_async_err", {24'd0, a_err_count}, 32'd0);
    chk("t5_async_flags", {29'd0, a_out_zero, a_out_code}, 32'd0);
    cyc();
    a_rst_n = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_stale", {31'd0, a_out_valid}, 32'd0);
    end
    a_in_valid = 1'b1; a_in_data = 4'b0100;
    cyc();
    chk("t5_after_code", {30'd0, a_out_code}, 32'd2);
    a_in_valid = 1'b0;
    cyc();

    // Test 6: random valid/ready over 1000 words on N=8
    b_rst_n = 1'b1;
    cyc();
    sent = 0; inv = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      guard++;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 7);
      if (r == 0)      b_in_data = 8'd0;
      else if (r == 1) b_in_data = 8'($urandom);
      else             b_in_data = 8'(1 << $urandom_range(0, 7));
      if (b_in_valid && b_in_ready) begin
        sent++;
        if (b_in_data == 8'd0 || $countones(b_in_data) > 1) inv++;
      end
      cyc();
    end
    chk("t6_sent", 32'(sent), 32'd1000);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    guard = 0;
    while ((qb.size() != 0 || b_out_valid) && guard < 200) begin
      guard++;
      cyc();
    end
    chk("t6_drained", 32'(qb.size()), 32'd0);
    chk("t6_outputs", 32'(b_outs), 32'd1000);
    chk("t6_err_count", {24'd0, b_err_count}, (inv > 255) ? 32'd255 : 32'(inv));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
